// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract unit with start/done handshake.
// Each CALC cycle handles CHUNK bits, starting from the least significant chunk.
// It produces a result plus carry/borrow, signed overflow, zero and negative flags.
// Optional build macro ADDSUB_SATURATE_EN clamps the result on signed overflow.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub_r;
  logic             carry;
  logic [IW-1:0]    idx;

  int               base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] res_final;
  logic             ovf_next;
  logic             last;

  // One chunk of the ripple addition, plus the flag values seen after the last chunk
  always_comb begin
    base      = CHUNK * int'(idx);
    a_chunk   = CHUNK'(op_a >> base);
    b_chunk   = CHUNK'(op_b >> base);
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    res_next  = (result & ~(CMASK << base)) | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
    // Same-signed operands giving a differently-signed sum is exactly carry-in XOR carry-out at the MSB
    ovf_next  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res_next[WIDTH-1] != op_a[WIDTH-1]);
    res_final = res_next;
`ifdef ADDSUB_SATURATE_EN
    if (ovf_next) begin
      res_final = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    res_final = res_next;
`endif
    last = (idx == IW'(NCHUNK - 1));
  end

  // Control FSM and datapath registers; b is inverted at capture so subtraction is a + ~b + 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      sub_r  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            sub_r <= sub;
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          carry <= chunk_sum[CHUNK];
          if (last) begin
            result <= res_final;
            cout   <= chunk_sum[CHUNK] ^ sub_r;
            ovf    <= ovf_next;
            zero   <= (res_final == '0);
            neg    <= res_final[WIDTH-1];
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            result <= res_next;
            idx    <= idx + IW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed table, multi-cycle corner
// sequences, and random operations against an arithmetic reference model.
module tb_addsub_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       neg;

  logic       sp_start;
  logic       sp_sub;
  logic [7:0] sp_a;
  logic [7:0] sp_b;
  logic       sp_busy;
  logic       sp_done;
  logic [7:0] sp_result;
  logic       sp_cout;
  logic       sp_ovf;
  logic       sp_zero;
  logic       sp_neg;

  int tests;
  int failures;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
  } vec_t;

  addsub_serial #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .zero(zero), .neg(neg)
  );

  addsub_serial #(.WIDTH(8), .CHUNK(8)) dut_sp (
    .clk(clk), .rst_n(rst_n), .start(sp_start), .sub(sp_sub), .a(sp_a), .b(sp_b),
    .busy(sp_busy), .done(sp_done), .result(sp_result), .cout(sp_cout), .ovf(sp_ovf),
    .zero(sp_zero), .neg(sp_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operands
  function automatic vec_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
    vec_t r;
    int   sres;
    int   ures;
    int   ai;
    int   bi;
    ai   = $signed(x);
    bi   = $signed(y);
    sres = s ? ai - bi : ai + bi;
    ures = s ? int'(x) - int'(y) : int'(x) + int'(y);
    r.sub  = s;
    r.a    = x;
    r.b    = y;
    r.ovf  = (sres > 127) || (sres < -128);
    r.cout = s ? (x < y) : (ures > 255);
    r.res  = ures[7:0];
`ifdef ADDSUB_SATURATE_EN
    if (r.ovf) r.res = x[7] ? 8'h80 : 8'h7F;
`endif
    r.zero = (r.res == 8'h00);
    r.neg  = r.res[7];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive start for one capture edge, then scramble the inputs
  task automatic applyStimulus(input logic s, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    sub   = $urandom_range(0, 1);
    a     = 8'($urandom);
    b     = 8'($urandom);
  endtask

  task automatic waitDone(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic checkVec(input string tag, input vec_t e);
    checkOutput({tag, " result"}, 32'(result), 32'(e.res));
    checkOutput({tag, " cout"}, 32'(cout), 32'(e.cout));
    checkOutput({tag, " ovf"}, 32'(ovf), 32'(e.ovf));
    checkOutput({tag, " zero"}, 32'(zero), 32'(e.zero));
    checkOutput({tag, " neg"}, 32'(neg), 32'(e.neg));
  endtask

  vec_t table_v[8];

  initial begin
    int   cyc;
    int   bcnt;
    vec_t e;
    vec_t prev;
    int   sp_cyc;
    logic saw_done;

    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    sp_start = 1'b0;
    sp_sub   = 1'b0;
    sp_a     = '0;
    sp_b     = '0;

`ifdef ADDSUB_SATURATE_EN
    table_v[0] = '{1'b1, 8'h50, 8'h30, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[1] = '{1'b1, 8'h30, 8'h50, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b1};
    table_v[2] = '{1'b1, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    table_v[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    table_v[4] = '{1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    table_v[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    table_v[6] = '{1'b0, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    table_v[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
`else
    table_v[0] = '{1'b1, 8'h50, 8'h30, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[1] = '{1'b1, 8'h30, 8'h50, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b1};
    table_v[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    table_v[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    table_v[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    table_v[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    table_v[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    table_v[7] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

    // Reset state
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkVec("reset", '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; each op starts from IDLE
    for (int i = 0; i < 8; i++) begin
      applyStimulus(table_v[i].sub, table_v[i].a, table_v[i].b);
      waitDone(cyc, bcnt);
      checkOutput($sformatf("vec%0d latency", i), 32'(cyc), 32'd4);
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'd4);
      checkVec($sformatf("vec%0d", i), table_v[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
      checkOutput($sformatf("vec%0d idle busy", i), 32'(busy), 32'd0);
      checkOutput($sformatf("vec%0d flags hold", i), 32'(result), 32'(table_v[i].res));
    end

    // start during CALC is ignored
    applyStimulus(1'b1, 8'h50, 8'h30);
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc, bcnt);
    checkOutput("ignored start latency", 32'(cyc), 32'd2);
    checkVec("ignored start", table_v[0]);

    // start held in the DONE cycle launches the next op without an IDLE cycle
    start = 1'b1;
    sub   = 1'b1;
    a     = 8'h30;
    b     = 8'h50;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b busy", 32'(busy), 32'd1);
    checkOutput("b2b done", 32'(done), 32'd0);
    checkOutput("b2b cout held", 32'(cout), 32'd0);
    waitDone(cyc, bcnt);
    checkOutput("b2b latency", 32'(cyc), 32'd4);
    checkVec("b2b", table_v[1]);

    // Random operations against the model, back-to-back or with idle gaps
    prev = table_v[1];
    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(posedge clk);
      e = model(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      applyStimulus(e.sub, e.a, e.b);
      checkOutput($sformatf("rnd%0d cout hold", i), 32'(cout), 32'(prev.cout));
      checkOutput($sformatf("rnd%0d ovf hold", i), 32'(ovf), 32'(prev.ovf));
      waitDone(cyc, bcnt);
      checkOutput($sformatf("rnd%0d latency", i), 32'(cyc), 32'd4);
      checkVec($sformatf("rnd%0d", i), e);
      prev = e;
    end

    // Reset mid-CALC clears outputs immediately and suppresses done
    applyStimulus(1'b0, 8'hFF, 8'h01);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkVec("abort", '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort no done", 32'(saw_done), 32'd0);

    // Single-pass instance: done one edge after capture
    @(negedge clk);
    sp_start = 1'b1;
    sp_sub   = 1'b1;
    sp_a     = 8'h05;
    sp_b     = 8'h07;
    @(posedge clk);
    #1;
    sp_start = 1'b0;
    sp_a     = 8'hAA;
    sp_b     = 8'h00;
    sp_cyc   = 0;
    while (!sp_done && sp_cyc < 20) begin
      @(posedge clk);
      #1;
      sp_cyc++;
    end
    checkOutput("single latency", 32'(sp_cyc), 32'd1);
    checkOutput("single result", 32'(sp_result), 32'h0FE);
    checkOutput("single cout", 32'(sp_cout), 32'd1);
    checkOutput("single ovf", 32'(sp_ovf), 32'd0);
    checkOutput("single neg", 32'(sp_neg), 32'd1);
    checkOutput("single zero", 32'(sp_zero), 32'd0);
    checkOutput("single busy", 32'(sp_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
